// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - RS(255,239) code constants and encoder controller state codes
package rs_pkg;

  localparam int RS_N     = 255;
  localparam int RS_K     = 239;
  localparam int RS_NPAR  = 16;
  localparam int RS_SYM_W = 8;
  localparam int RS_FLUSH = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MSG   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_PAR   = 2'd3;

endpackage

// File: rtl/rs_enc_ctrl.sv
// rtl/rs_enc_ctrl.sv - sequencing controller for the RS(255,239) parity LFSR
// Passes message symbols through, drains the stage pipeline, then shifts parity out of r_15.
module rs_enc_ctrl
  import rs_pkg::*;
#(
  parameter int K     = RS_K,
  parameter int NPAR  = RS_NPAR,
  parameter int FLUSH = RS_FLUSH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic [7:0] msg_data,
  output logic       fb_en,
  output logic       dp_en,
  output logic       lfsr_clr,
  input  logic [7:0] par_in,
  output logic       err_len
);

  localparam logic [7:0] K_LAST = 8'(K - 1);
  localparam logic [7:0] P_LAST = 8'(NPAR - 1);
  localparam logic [7:0] F_LAST = 8'(FLUSH - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       clr_q, clr_d;
  logic       err_q, err_d;
  logic       m_valid_q, m_valid_d;
  logic       m_last_q, m_last_d;
  logic [7:0] m_data_q, m_data_d;
  logic       slot_free, accept, par_load;

  always_comb begin
    slot_free = !m_valid_q || m_ready;
    accept    = (state_q == ST_MSG) && s_valid && slot_free;
    par_load  = (state_q == ST_PAR) && slot_free;
    s_ready   = (state_q == ST_MSG) && slot_free;
    fb_en     = accept;
    msg_data  = accept ? s_data : 8'h00;
    // FLUSH clocks the stages unconditionally; everything else only moves on a handshake
    dp_en     = accept || par_load || (state_q == ST_FLUSH);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_d     = 1'b0;
    err_d     = err_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (clr_q) state_d = ST_MSG;
        else       clr_d   = 1'b1;
      end
      ST_MSG: begin
        if (accept) begin
          if (s_last != (cnt_q == K_LAST)) err_d = 1'b1;
          if (cnt_q == K_LAST) begin
            state_d = ST_FLUSH;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_FLUSH: begin
        if (cnt_q == F_LAST) begin
          state_d = ST_PAR;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        if (par_load) begin
          if (cnt_q == P_LAST) begin
            // Enter IDLE with the clear already armed so back-to-back codewords lose one cycle only
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            clr_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
    endcase

    if (accept) begin
      m_data_d  = s_data;
      m_valid_d = 1'b1;
      m_last_d  = 1'b0;
    end else if (par_load) begin
      m_data_d  = par_in;
      m_valid_d = 1'b1;
      m_last_d  = (cnt_q == P_LAST);
    end else if (m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      clr_q     <= 1'b0;
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_q     <= clr_d;
      err_q     <= err_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign lfsr_clr = clr_q;
  assign err_len  = err_q;

endmodule

// File: tb/tb_rs_enc_ctrl.sv
// tb/tb_rs_enc_ctrl.sv - scoreboard bench for rs_enc_ctrl with a behavioural parity datapath
module tb_rs_enc_ctrl;

  localparam int K = 239;
  localparam int NPAR = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready, s_last;
  logic [7:0] s_data;
  logic       m_valid, m_ready, m_last;
  logic [7:0] m_data, msg_data, par_in;
  logic       fb_en, dp_en, lfsr_clr, err_len;

  rs_enc_ctrl dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .msg_data(msg_data), .fb_en(fb_en), .dp_en(dp_en), .lfsr_clr(lfsr_clr),
    .par_in(par_in), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  logic [7:0] gen [0:16];

  // Datapath stand-in: LFSR r_0..r_15 plus the two-register drain behind r_15
  logic [7:0] r_m [0:15];
  logic [7:0] p1_m, p2_m, fb_m;
  assign fb_m   = fb_en ? (r_m[15] ^ msg_data) : 8'h00;
  assign par_in = p2_m;
  always @(posedge clk) begin
    if (lfsr_clr) begin
      for (int i = 0; i < 16; i++) r_m[i] <= 8'h00;
    end else if (dp_en) begin
      r_m[0] <= gmul(fb_m, gen[0]);
      for (int i = 1; i < 16; i++) r_m[i] <= r_m[i-1] ^ gmul(fb_m, gen[i]);
      p1_m <= r_m[15];
      p2_m <= p1_m;
    end
  end

  logic [7:0] msg_buf [0:K-1];
  logic [7:0] exp_par [0:NPAR-1];
  logic [8:0] sb [$];

  task automatic compute_parity();
    logic [7:0] a [0:254];
    logic [7:0] c;
    for (int i = 0; i < 255; i++) a[i] = (i < K) ? msg_buf[i] : 8'h00;
    for (int i = 0; i < K; i++) begin
      c = a[i];
      for (int j = 1; j <= NPAR; j++) a[i+j] = a[i+j] ^ gmul(c, gen[NPAR-j]);
    end
    for (int i = 0; i < NPAR; i++) exp_par[i] = a[K+i];
  endtask

  logic stall_s = 1'b0;
  logic stall_m = 1'b0;

  task automatic send_cw(input int last_at);
    bit acc;
    int waited;
    compute_parity();
    for (int i = 0; i < K; i++) sb.push_back({1'b0, msg_buf[i]});
    for (int i = 0; i < NPAR; i++) sb.push_back({(i == NPAR-1), exp_par[i]});
    for (int i = 0; i < K; i++) begin
      acc = 1'b0;
      waited = 0;
      while (!acc) begin
        if (stall_s && $urandom_range(0, 1) == 0) begin
          s_valid = 1'b0;
        end else begin
          s_valid = 1'b1;
          s_data  = msg_buf[i];
          s_last  = (i == last_at);
        end
        @(negedge clk);
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        waited++;
        if (waited > 1000) begin
          check("src_timeout", 32'd1, 32'd0);
          s_valid = 1'b0;
          return;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = stall_m ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int out_idx = 0;
  int cw_num = 0;
  int clr_cnt = 0;
  int dp_viol = 0;
  int stab_viol = 0;
  bit mon_en = 1'b0;
  bit arm_p5 = 1'b0;
  bit par5_seen = 1'b0;
  int t0 [0:15];
  int t238 [0:15];
  int t239 [0:15];
  int clr_at0 [0:15];
  int clr_at254 [0:15];

  initial begin
    logic [8:0] e;
    bit hold_prev;
    logic [7:0] prev_data;
    hold_prev = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        out_idx = 0;
        sb.delete();
        hold_prev = 1'b0;
      end else begin
        if (mon_en) begin
          if (dp_en && fb_en && !(s_valid && s_ready)) dp_viol++;
          if (dp_en && !fb_en && out_idx >= K && m_valid && !m_ready) dp_viol++;
          if (hold_prev && !(m_valid && m_data == prev_data)) stab_viol++;
        end
        hold_prev = m_valid && !m_ready;
        prev_data = m_data;
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("cw_sym", {m_last, m_data}, e);
          end
          if (cw_num < 16) begin
            if (out_idx == 0)   begin t0[cw_num] = cyc; clr_at0[cw_num] = clr_cnt; end
            if (out_idx == 238) t238[cw_num] = cyc;
            if (out_idx == 239) t239[cw_num] = cyc;
            if (out_idx == 254) clr_at254[cw_num] = clr_cnt;
          end
          if (out_idx == K + 5 && arm_p5) par5_seen = 1'b1;
          if (out_idx == 254) begin
            out_idx = 0;
            cw_num++;
          end else begin
            out_idx++;
          end
        end
        if (lfsr_clr) clr_cnt++;
      end
    end
  end

  initial begin
    logic [7:0] a;
    for (int i = 0; i <= 16; i++) gen[i] = 8'h00;
    gen[0] = 8'h01;
    a = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int j = 16; j >= 1; j--) gen[j] = gen[j-1] ^ gmul(gen[j], a);
      gen[0] = gmul(gen[0], a);
      a = gmul(a, 8'h02);
    end

    rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_fb_en", fb_en, 0);
    check("rst_dp_en", dp_en, 0);
    check("rst_lfsr_clr", lfsr_clr, 0);
    check("rst_err_len", err_len, 0);
    check("rst_msg_data", msg_data, 0);

    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_clr", lfsr_clr, 1);
    check("idle_s_ready", s_ready, 0);
    @(posedge clk); #1;
    check("first_s_ready", s_ready, 1);
    check("clr_one_cycle", lfsr_clr, 0);

    // Two all-zero codewords then 1..239, all back to back at full rate
    for (int i = 0; i < K; i++) msg_buf[i] = 8'h00;
    send_cw(K-1);
    send_cw(K-1);
    for (int i = 0; i < K; i++) msg_buf[i] = 8'(i + 1);
    send_cw(K-1);
    wait_drain(2000);
    check("period", t0[1] - t0[0], 258);
    check("period_b2b", t0[2] - t0[1], 258);
    check("msg_par_gap", t239[0] - t238[0], 3);
    check("clr_between_01", clr_at0[1] - clr_at254[0], 1);
    check("clr_between_12", clr_at0[2] - clr_at254[1], 1);

    // Random message under 50% stalls on both sides
    for (int i = 0; i < K; i++) msg_buf[i] = 8'($urandom);
    stall_s = 1'b1; stall_m = 1'b1; mon_en = 1'b1;
    send_cw(K-1);
    wait_drain(4000);
    mon_en = 1'b0; stall_s = 1'b0; stall_m = 1'b0;
    check("dp_en_gated", dp_viol, 0);
    check("m_hold_stable", stab_viol, 0);
    check("err_len_clean", err_len, 0);

    // Early s_last: error flagged, framing unchanged
    for (int i = 0; i < K; i++) msg_buf[i] = 8'($urandom);
    send_cw(100);
    wait_drain(2000);
    check("err_len_set", err_len, 1);

    // Reset in the middle of parity readout
    for (int i = 0; i < K; i++) msg_buf[i] = 8'($urandom);
    arm_p5 = 1'b1;
    send_cw(K-1);
    for (int i = 0; i < 2000 && !par5_seen; i++) begin
      @(posedge clk); #1;
    end
    check("par5_reached", par5_seen, 1);
    check("err_len_sticky", err_len, 1);
    arm_p5 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midpar_m_valid", m_valid, 0);
    check("midpar_s_ready", s_ready, 0);
    check("midpar_err_len", err_len, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midpar_clr", lfsr_clr, 1);
    for (int i = 0; i < K; i++) msg_buf[i] = 8'($urandom);
    send_cw(K-1);
    wait_drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
